// File: rtl/uart_fifo_gen.sv
// Purpose : parametrised first-word-fall-through FIFO for the UART 16550 TX/RX datapath.
// Latency : a word pushed into an empty FIFO appears on dout one edge later; a pop moves dout to the next word one edge later.
// Backpr. : no stall signals. A push to a full FIFO without a pop is dropped and sets the sticky overrun flag.
//           A pop from an empty FIFO is ignored and sets the sticky underrun flag.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              gates push/pop/err_clr; state holds when low
//   flush           synchronous clear of pointers, count and flags (ignores en)
//   err_clr         clears the sticky overrun/underrun flags
//   push, din       write request and data
//   pop             read request
//   threshold       trigger level for thre_trigger; 0 disables the trigger
//   dout            head-of-FIFO word, zero when empty
//   count           stored entries, 0..DEPTH
//   empty, full     fill-level status
//   overrun         sticky error flag for a push into a full FIFO
//   underrun        sticky error flag for a pop from an empty FIFO
//   thre_trigger    high when the count has reached a non-zero threshold
module uart_fifo_gen #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             err_clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic [AW:0]      threshold,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic             underrun,
  output logic             thre_trigger
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  logic push_ok;
  logic pop_ok;
  logic ovr_set;
  logic udr_set;

  // Status comes straight from the count register, so push/pop never reach an output combinationally.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A pop frees the slot that a simultaneous push fills, so a full FIFO still accepts the push.
  assign push_ok = push & en & (~full | pop);
  assign pop_ok  = pop & en & ~empty;
  assign ovr_set = push & en & full & ~pop;
  assign udr_set = pop & en & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (en) begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;

      if (push_ok && !pop_ok)      count <= count + ONE_C;
      else if (pop_ok && !push_ok) count <= count - ONE_C;

      // A new error event wins over a clear issued in the same cycle.
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;

      if (udr_set)      underrun <= 1'b1;
      else if (err_clr) underrun <= 1'b0;
    end
  end

  // Storage has no reset: after reset or flush the pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && rst_n) mem[wp] <= din;
  end

  assign dout = empty ? '0 : mem[rp];

  // count never exceeds DEPTH, so a threshold above DEPTH can never fire.
  assign thre_trigger = (threshold != '0) && (count >= threshold);

endmodule

// File: doc/uart_fifo_gen.md
# uart_fifo_gen

Parametrised FIFO for the UART 16550 datapath, the next generation of the TX/RX FIFO used between the host register interface and the shift engines. It is generic in data width and depth. Over the fixed 16×8 version it adds a fill-level output, a synchronous flush, simultaneous push/pop on full and empty, sticky error flags with an explicit clear, and a disable-able threshold trigger. One instance serves as the TX FIFO and one as the RX FIFO.

## Interface
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- en  input  1  enable; when low, push/pop/err_clr are ignored and state holds.
- flush  input  1  synchronous FIFO clear (16550 FCR reset bit); independent of en.
- err_clr  input  1  clears sticky overrun/underrun.
- push  input  1  write request.
- pop  input  1  read request.
- din  input  WIDTH  write data.
- threshold  input  AW+1  trigger level; 0 disables trigger.
- dout  output  WIDTH  head-of-FIFO word (first-word fall-through).
- count  output  AW+1  number of stored entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overrun  output  1  sticky: push attempted while full without a pop.
- underrun  output  1  sticky: pop attempted while empty.
- thre_trigger  output  1  threshold != 0 and count ≥ threshold.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp and read pointer rp, both AW bits wide and wrapping modulo DEPTH. count is an AW+1-bit register held separately.
- Priority per edge: rst_n low > flush > en low > normal operation.
- Flush: wp = rp = 0, count = 0, overrun = underrun = 0. Array contents are not cleared. Push and pop in the same cycle are discarded.
- Push is accepted when push & en & (!full | pop). It writes mem[wp] = din and increments wp.
- Pop is accepted when pop & en & !empty. It increments rp.
- count updates by +1 (push only), −1 (pop only) or unchanged (both, or neither).
- Full with push & pop: both are accepted. Count stays DEPTH and overrun is not set.
- Empty with push & pop: push is accepted, pop is rejected, underrun is set, and count becomes 1.
- Overrun sets on push & en & full & !pop. The data is dropped and pointers are unchanged.
- Underrun sets on pop & en & empty. Pointers are unchanged.
- Setting has priority over err_clr in the same cycle. Both flags stay at 1 until err_clr & en, flush, or reset.
- dout = mem[rp] when !empty, otherwise all zeros.
- threshold is sampled live. Values > DEPTH never trigger.

## Timing
- Reset values: count 0, empty 1, full 0, overrun 0, underrun 0, thre_trigger 0, dout 0, wp = rp = 0.
- count, empty, full, overrun, underrun and pointers are registered and change on the edge after the request.
- thre_trigger is combinational from registered count and the threshold input.
- Write-to-read latency: data pushed at edge N appears on dout after edge N (visible in cycle N+1) if the FIFO was empty.
- dout follows the new head in the cycle after a pop edge.
- No combinational path from push/pop/din to any output.
- Asserting rst_n low mid-transfer forces all reset values immediately, without waiting for clk. Release is synchronous to the next edge: the first push is accepted on the first edge with rst_n high.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with push=1 → empty=1, count=0, dout=0; release → first push accepted next edge.
- Fill/overrun (DEPTH=16, WIDTH=8): 20 pushes of 0x01..0x14 with en=1 → full after the 16th, count=16, overrun=1 after the 17th; 16 pops return 0x01..0x10 in order; pushes 17–20 are never read.
- Underrun/clear: with the FIFO empty, pop=1 → underrun=1, count=0; err_clr with pop=1 in the same cycle → underrun stays 1; err_clr alone → 0.
- Simultaneous push/pop:
  - At full: count stays 16, overrun=0, and dout advances.
  - At empty: count → 1, underrun=1, and dout equals the pushed word.
- Threshold: threshold=10, push 9 → thre_trigger=0; push 10th → 1; pop one → 0; threshold=0 with 16 entries → 0.
- Flush/wrap: push 12, pop 12, push 8 (pointers wrap), then flush with push=1 → count=0, empty=1, flags clear; next pushes read back correctly from address 0.
